dram_req_arbiter: RTL and testbench

- Shares one AXI4 single-beat DRAM port between two requesters (M1, M2); each requester issues a read or write of one 64-bit DRAM word selected by an 8-bit dram_no.
- Grants round-robin, runs the AR/R or AW/W/B sequence, and returns read data with a done pulse.
- Holds a one-entry last-access buffer, so a read that hits the most recently read or written word completes without a DRAM transaction.
- Sits between the two-master front end and the DRAM AXI slave.

---
 rtl/dram_req_arbiter_pkg.sv | 8 +
 rtl/dram_req_arbiter_rr_arb2.sv | 15 +
 rtl/dram_req_arbiter.sv | 137 +++++++++++++
 tb/tb_dram_req_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_req_arbiter_pkg.sv
// dram_req_arbiter_pkg: shared widths, DRAM base address and FSM state encoding
package dram_req_arbiter_pkg;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 64;
  localparam int NO_W = 8;
  localparam logic [ADDR_W-1:0] ADDR_BASE = 17'h10000;
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;
endpackage

// File: rtl/dram_req_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; last == 1 means M2 was served last
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       served,
  output logic       gnt
);
  logic last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (upd) last <= served;
  assign gnt = &req ? ~last : req[1];
endmodule

// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter: shares one single-beat AXI4 DRAM port between two requesters
module dram_req_arbiter #(
  parameter int ADDR_W = dram_req_arbiter_pkg::ADDR_W,
  parameter int DATA_W = dram_req_arbiter_pkg::DATA_W,
  parameter int NO_W = dram_req_arbiter_pkg::NO_W,
  parameter logic [ADDR_W-1:0] ADDR_BASE = dram_req_arbiter_pkg::ADDR_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req1,
  input  logic              req2,
  input  logic              we1,
  input  logic              we2,
  input  logic [NO_W-1:0]   no1,
  input  logic [NO_W-1:0]   no2,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  input  logic              flush,
  output logic              done1,
  output logic              done2,
  output logic [DATA_W-1:0] rdata,
  output logic              AR_VALID,
  output logic [ADDR_W-1:0] AR_ADDR,
  output logic              R_READY,
  output logic              AW_VALID,
  output logic [ADDR_W-1:0] AW_ADDR,
  output logic              W_VALID,
  output logic [DATA_W-1:0] W_DATA,
  output logic              B_READY,
  input  logic              AR_READY,
  input  logic              R_VALID,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic              AW_READY,
  input  logic              W_READY,
  input  logic              B_VALID
);
  import dram_req_arbiter_pkg::*;
  state_t state;
  logic owner, gnt, buf_v;
  logic [NO_W-1:0] cur_no, buf_tag, g_no;
  logic [DATA_W-1:0] cur_wd, buf_data;
  logic [ADDR_W-1:0] g_addr;
  assign g_no = gnt ? no2 : no1;
  assign g_addr = ADDR_BASE + (ADDR_W'(g_no) << 3);
  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req2, req1}),
    .upd    (state == S_DONE),
    .served (owner),
    .gnt    (gnt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= S_IDLE;
      owner    <= 1'b0;
      cur_no   <= '0;
      cur_wd   <= '0;
      buf_v    <= 1'b0;
      buf_tag  <= '0;
      buf_data <= '0;
      done1    <= 1'b0;
      done2    <= 1'b0;
      rdata    <= '0;
      AR_VALID <= 1'b0;
      AR_ADDR  <= '0;
      R_READY  <= 1'b0;
      AW_VALID <= 1'b0;
      AW_ADDR  <= '0;
      W_VALID  <= 1'b0;
      W_DATA   <= '0;
      B_READY  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req1 || req2) begin
          owner  <= gnt;
          cur_no <= g_no;
          cur_wd <= gnt ? wdata2 : wdata1;
          if (gnt ? we2 : we1) begin
            state    <= S_AW;
            AW_VALID <= 1'b1;
            AW_ADDR  <= g_addr;
          end else if (buf_v && buf_tag == g_no) begin
            state          <= S_DONE;
            rdata          <= buf_data;
            {done2, done1} <= gnt ? 2'b10 : 2'b01;
          end else begin
            state    <= S_AR;
            AR_VALID <= 1'b1;
            AR_ADDR  <= g_addr;
          end
        end
        S_AR: if (AR_READY) begin
          AR_VALID <= 1'b0;
          R_READY  <= 1'b1;
          state    <= S_R;
        end
        S_R: if (R_VALID) begin
          R_READY        <= 1'b0;
          rdata          <= R_DATA;
          buf_v          <= 1'b1;
          buf_tag        <= cur_no;
          buf_data       <= R_DATA;
          {done2, done1} <= owner ? 2'b10 : 2'b01;
          state          <= S_DONE;
        end
        S_AW: if (AW_READY) begin
          AW_VALID <= 1'b0;
          W_VALID  <= 1'b1;
          W_DATA   <= cur_wd;
          state    <= S_W;
        end
        S_W: if (W_READY) begin
          W_VALID <= 1'b0;
          B_READY <= 1'b1;
          state   <= S_B;
        end
        S_B: if (B_VALID) begin
          B_READY        <= 1'b0;
          rdata          <= '0;
          buf_v          <= 1'b1;
          buf_tag        <= cur_no;
          buf_data       <= cur_wd;
          {done2, done1} <= owner ? 2'b10 : 2'b01;
          state          <= S_DONE;
        end
        S_DONE: begin
          done1 <= 1'b0;
          done2 <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // a flush in the same cycle as a fill leaves the buffer invalid
      if (flush) buf_v <= 1'b0;
    end
endmodule

// File: tb/tb_dram_req_arbiter.sv
// tb_dram_req_arbiter: randomized scoreboard bench with an AXI slave model and a last-access reference model
module tb_dram_req_arbiter;
  logic clk = 0, rst_n = 0;
  logic req1 = 0, req2 = 0, we1 = 0, we2 = 0, flush = 0;
  logic [7:0] no1 = 0, no2 = 0;
  logic [63:0] wdata1 = 0, wdata2 = 0;
  logic done1, done2, AR_VALID, R_READY, AW_VALID, W_VALID, B_READY;
  logic [63:0] rdata, W_DATA;
  logic [16:0] AR_ADDR, AW_ADDR;
  logic AR_READY = 0, R_VALID = 0, AW_READY = 0, W_READY = 0, B_VALID = 0;
  logic [63:0] R_DATA = 0;

  always #5 clk = ~clk;

  dram_req_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req1(req1), .req2(req2), .we1(we1), .we2(we2),
    .no1(no1), .no2(no2), .wdata1(wdata1), .wdata2(wdata2), .flush(flush),
    .done1(done1), .done2(done2), .rdata(rdata),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .W_VALID(W_VALID), .W_DATA(W_DATA),
    .B_READY(B_READY), .AR_READY(AR_READY), .R_VALID(R_VALID), .R_DATA(R_DATA),
    .AW_READY(AW_READY), .W_READY(W_READY), .B_VALID(B_VALID)
  );

  typedef struct packed {logic owner; logic [63:0] data;} exp_t;
  exp_t exp_q[$];
  logic [16:0] ar_q[$], aw_q[$];
  logic [63:0] w_q[$];
  logic [63:0] dram [256];
  logic [63:0] ref_mem [256];
  int checks = 0, errors = 0;
  bit m_v = 0, m_last = 1;
  logic [7:0] m_tag = 0;
  logic [63:0] m_data = 0;
  bit hold_r = 0, pend_r = 0, pend_b = 0, pd1 = 0, pd2 = 0;
  logic [7:0] r_no = 0, w_no = 0;

  function automatic logic [16:0] addr_of(input logic [7:0] n);
    return 17'h10000 + 17'(n) * 17'd8;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected by the model", name);
  endtask

  // AXI slave: random ready/response delays, memory in dram[]
  initial forever begin
    @(negedge clk);
    R_VALID = 0;
    B_VALID = 0;
    if (!rst_n) begin
      pend_r = 0; pend_b = 0; AR_READY = 0; AW_READY = 0; W_READY = 0;
    end else begin
      AR_READY = AR_VALID && ($urandom_range(0, 2) == 0);
      if (AR_VALID && AR_READY) begin
        if (ar_q.size() == 0) fail("unexpected_ar");
        else check("ar_addr", 64'(AR_ADDR), 64'(ar_q.pop_front()));
        r_no = 8'((AR_ADDR - 17'h10000) >> 3);
        pend_r = 1;
      end
      if (pend_r && R_READY && (hold_r || $urandom_range(0, 1) == 1)) begin
        R_VALID = 1;
        R_DATA = dram[r_no];
        if (!hold_r) pend_r = 0;
      end
      AW_READY = AW_VALID && ($urandom_range(0, 2) == 0);
      if (AW_VALID && AW_READY) begin
        if (aw_q.size() == 0) fail("unexpected_aw");
        else check("aw_addr", 64'(AW_ADDR), 64'(aw_q.pop_front()));
        w_no = 8'((AW_ADDR - 17'h10000) >> 3);
      end
      W_READY = W_VALID && ($urandom_range(0, 1) == 1);
      if (W_VALID && W_READY) begin
        if (w_q.size() == 0) fail("unexpected_w");
        else check("w_data", W_DATA, w_q.pop_front());
        dram[w_no] = W_DATA;
        pend_b = 1;
      end
      if (pend_b && B_READY && $urandom_range(0, 1) == 1) begin
        B_VALID = 1;
        pend_b = 0;
      end
    end
  end

  // completion monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (done1 || done2) begin
        check("both_done", 64'(done1 & done2), 0);
        check("done_width", 64'((done1 & pd1) | (done2 & pd2)), 0);
        if (exp_q.size() == 0) fail("unexpected_done");
        else begin
          e = exp_q.pop_front();
          check("owner", 64'(done2), 64'(e.owner));
          check("rdata", rdata, e.data);
        end
      end
      pd1 = done1;
      pd2 = done2;
    end
  end

  // reference model: single-entry last-access buffer plus alternating grant
  task automatic predict(input bit o, input bit w, input logic [7:0] n, input logic [63:0] d,
                         input bit fl, output bit hit);
    hit = 0;
    if (w) begin
      aw_q.push_back(addr_of(n));
      w_q.push_back(d);
      exp_q.push_back({o, 64'h0});
      ref_mem[n] = d;
      m_v = 1; m_tag = n; m_data = d;
    end else if (m_v && m_tag == n) begin
      hit = 1;
      exp_q.push_back({o, m_data});
    end else begin
      ar_q.push_back(addr_of(n));
      exp_q.push_back({o, ref_mem[n]});
      m_v = 1; m_tag = n; m_data = ref_mem[n];
    end
    if (fl) m_v = 0;
    m_last = o;
  endtask

  task automatic run(input bit e1, input bit e2, input bit w1, input bit w2,
                     input logic [7:0] n1, input logic [7:0] n2,
                     input logic [63:0] d1, input logic [63:0] d2, input bit fl);
    bit first, o, hit, lat, dr1, dr2, seen;
    int cyc;
    lat = 0;
    first = (e1 && e2) ? ~m_last : e2;
    for (int k = 0; k < 2; k++) begin
      o = (k == 0) ? first : ~first;
      if (o ? e2 : e1) begin
        predict(o, o ? w2 : w1, o ? n2 : n1, o ? d2 : d1, fl, hit);
        lat = hit && !(e1 && e2);
      end
    end
    @(posedge clk); #1;
    req1 = e1; req2 = e2; we1 = w1; we2 = w2; no1 = n1; no2 = n2;
    wdata1 = d1; wdata2 = d2; flush = fl;
    cyc = 0; dr1 = 0; dr2 = 0; seen = 0;
    while (req1 || req2 || dr1 || dr2) begin
      @(posedge clk); #1;
      cyc++;
      if (dr1) begin req1 = 0; dr1 = 0; end
      if (dr2) begin req2 = 0; dr2 = 0; end
      if ((done1 && req1) || (done2 && req2)) begin
        if (lat && !seen) check("hit_latency", 64'(cyc), 1);
        seen = 1;
        if (done1) dr1 = 1;
        if (done2) dr2 = 1;
      end
      if (cyc > 400) begin
        fail("timeout");
        req1 = 0; req2 = 0; dr1 = 0; dr2 = 0;
      end
    end
    flush = 0;
  endtask

  task automatic reset_abort(input logic [7:0] n);
    int k;
    ar_q.push_back(addr_of(n));
    hold_r = 1;
    @(posedge clk); #1;
    req1 = 1; we1 = 0; no1 = n;
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #6;
      if (R_VALID) break;
    end
    if (k == 200) fail("r_wait_timeout");
    rst_n = 0;
    #1;
    check("abort_valids", 64'({AR_VALID, R_READY, AW_VALID, W_VALID, B_READY}), 0);
    check("abort_done", 64'({done1, done2}), 0);
    check("abort_ar_q", 64'(ar_q.size()), 0);
    req1 = 0; hold_r = 0;
    exp_q.delete();
    m_v = 0; m_last = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    logic [63:0] v;
    logic [7:0] pick [5];
    pick[0] = 8'h00; pick[1] = 8'h01; pick[2] = 8'h02; pick[3] = 8'h03; pick[4] = 8'hFF;
    for (int i = 0; i < 256; i++) begin
      v = {$urandom, $urandom};
      dram[i] = v;
      ref_mem[i] = v;
    end
    dram[5] = 64'hA5A5_A5A5_A5A5_A5A5;
    ref_mem[5] = 64'hA5A5_A5A5_A5A5_A5A5;
    repeat (2) @(negedge clk);
    check("rst_valids", 64'({AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, done1, done2}), 0);
    check("rst_ar_addr", 64'(AR_ADDR), 0);
    check("rst_aw_addr", 64'(AW_ADDR), 0);
    check("rst_w_data", W_DATA, 0);
    check("rst_rdata", rdata, 0);
    @(posedge clk); #1 rst_n = 1;
    run(1, 0, 0, 0, 8'h05, 8'h00, 0, 0, 0);
    run(0, 1, 0, 0, 8'h00, 8'h05, 0, 0, 0);
    run(1, 0, 1, 0, 8'h10, 8'h00, 64'h1234, 0, 0);
    run(0, 1, 0, 0, 8'h00, 8'h10, 0, 0, 0);
    run(1, 1, 0, 0, 8'h20, 8'h21, 0, 0, 0);
    run(1, 1, 0, 0, 8'h22, 8'h23, 0, 0, 0);
    run(1, 0, 0, 0, 8'h03, 8'h00, 0, 0, 0);
    @(posedge clk); #1 flush = 1;
    m_v = 0;
    @(posedge clk); #1 flush = 0;
    run(1, 0, 0, 0, 8'h03, 8'h00, 0, 0, 0);
    run(0, 1, 0, 0, 8'h00, 8'h07, 0, 0, 1);
    run(0, 1, 0, 0, 8'h00, 8'h07, 0, 0, 0);
    run(1, 0, 0, 0, 8'hFF, 8'h00, 0, 0, 0);
    run(0, 1, 0, 1, 8'h00, 8'hFF, 0, 64'hDEAD_BEEF_0BAD_F00D, 0);
    run(1, 0, 0, 0, 8'hFF, 8'h00, 0, 0, 0);
    run(1, 0, 0, 0, 8'h09, 8'h00, 0, 0, 0);
    reset_abort(8'h0A);
    run(1, 0, 0, 0, 8'h09, 8'h00, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      bit [1:0] m;
      m = 2'($urandom_range(1, 3));
      run(m[0], m[1], 1'($urandom), 1'($urandom), pick[$urandom_range(0, 4)], pick[$urandom_range(0, 4)],
          {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 7) == 0);
    end
    repeat (4) @(posedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 0);
    check("ar_q_empty", 64'(ar_q.size()), 0);
    check("aw_q_empty", 64'(aw_q.size()), 0);
    check("w_q_empty", 64'(w_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
